// File: rtl/expand3_layer_ctrl_if.sv
// Handshake and RAM-addressing bundle between the layer controller and its datapath.
// master is the controller side; slave is the datapath/environment side.
interface expand3_layer_ctrl_if #(
  parameter int WOUT = 16,
  parameter int CHIN = 64
);
  localparam int AW = $clog2(WOUT * WOUT * CHIN);
  localparam int OW = $clog2(WOUT * WOUT);

  logic          start;
  logic          hold;
  logic          layer_sample;
  logic          ram_feedback;
  logic [AW-1:0] ifm_rd_addr;
  logic          ifm_rd_en;
  logic          pad_zero;
  logic          layer_en;
  logic          ofm_wr_en;
  logic [OW-1:0] ofm_wr_addr;
  logic          busy;
  logic          done;

  modport master (
    input  start, hold, layer_sample, ram_feedback,
    output ifm_rd_addr, ifm_rd_en, pad_zero, layer_en,
    output ofm_wr_en, ofm_wr_addr, busy, done
  );

  modport slave (
    output start, hold, layer_sample, ram_feedback,
    input  ifm_rd_addr, ifm_rd_en, pad_zero, layer_en,
    input  ofm_wr_en, ofm_wr_addr, busy, done
  );
endinterface

// File: rtl/expand3_layer_ctrl.sv
// Sequencer for a padded KxK convolution layer: walks output pixels and kernel taps,
// generates input-feature read addresses with zero padding, and logs output writes.
module expand3_layer_ctrl #(
  parameter int WOUT       = 16,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int TAPS       = KERNEL_DIM * KERNEL_DIM * CHIN
) (
  input  logic                  clk,
  input  logic                  rst,
  expand3_layer_ctrl_if.master  bus
);
  localparam int NPIX = WOUT * WOUT;
  localparam int AW   = $clog2(WOUT * WOUT * CHIN);
  localparam int OW   = $clog2(NPIX);
  localparam int SW   = $clog2(NPIX + 1);
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW   = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int KW   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int PW   = (WOUT > 1) ? $clog2(WOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [PW-1:0] ox_q, ox_d;
  logic [PW-1:0] oy_q, oy_d;
  logic [SW-1:0] smp_q, smp_d;
  logic          fb_q, fb_d;
  logic          wr_en_q, wr_en_d;
  logic [OW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pad_q, pad_d;
  logic [31:0]   iy_sum, ix_sum, addr_full;
  logic          active;

  assign active = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    c_d       = c_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    smp_d     = smp_q;
    fb_d      = fb_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    pad_d     = 1'b0;
    addr_d    = '0;
    iy_sum    = '0;
    ix_sum    = '0;
    addr_full = '0;

    // Each accepted sample is written one cycle later at the running sample index.
    if (active && bus.layer_sample && (smp_q < SW'(NPIX))) begin
      wr_en_d   = 1'b1;
      wr_addr_d = OW'(smp_q);
      smp_d     = smp_q + SW'(1);
    end
    if (active && bus.ram_feedback) begin
      fb_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          tap_d   = '0;
          c_d     = '0;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          smp_d   = '0;
          fb_d    = 1'b0;
        end
      end
      RUN: begin
        if (!bus.hold) begin
          if (tap_q == TW'(TAPS - 1)) begin
            tap_d = '0;
            c_d   = '0;
            kx_d  = '0;
            ky_d  = '0;
            if (ox_q == PW'(WOUT - 1)) begin
              ox_d = '0;
              if (oy_q == PW'(WOUT - 1)) begin
                oy_d    = '0;
                state_d = DRAIN;
              end else begin
                oy_d = oy_q + PW'(1);
              end
            end else begin
              ox_d = ox_q + PW'(1);
            end
          end else begin
            tap_d = tap_q + TW'(1);
            if (c_q == CW'(CHIN - 1)) begin
              c_d = '0;
              if (kx_q == KW'(KERNEL_DIM - 1)) begin
                kx_d = '0;
                ky_d = ky_q + KW'(1);
              end else begin
                kx_d = kx_q + KW'(1);
              end
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (smp_d == SW'(NPIX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ram_feedback || fb_q) begin
          state_d = IDLE;
          fb_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address/pad are precomputed from the next tap so they line up with the read strobe.
    // iy_sum/ix_sum carry the +1 bias of the kernel offset so the math stays unsigned.
    if (state_d == RUN) begin
      iy_sum = 32'(oy_d) + 32'(ky_d);
      ix_sum = 32'(ox_d) + 32'(kx_d);
      if ((iy_sum == 32'd0) || (iy_sum > 32'(WOUT)) ||
          (ix_sum == 32'd0) || (ix_sum > 32'(WOUT))) begin
        pad_d = 1'b1;
      end else begin
        addr_full = ((iy_sum - 32'd1) * 32'(WOUT) + (ix_sum - 32'd1)) * 32'(CHIN)
                    + 32'(c_d);
        addr_d    = AW'(addr_full);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      c_q       <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      smp_q     <= '0;
      fb_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      addr_q    <= '0;
      pad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      c_q       <= c_d;
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      smp_q     <= smp_d;
      fb_q      <= fb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      addr_q    <= addr_d;
      pad_q     <= pad_d;
    end
  end

  // Strobes follow hold in the same cycle; everything else comes straight from flops.
  assign bus.ifm_rd_en   = (state_q == RUN) && !bus.hold;
  assign bus.layer_en    = (state_q == RUN) && !bus.hold;
  assign bus.ifm_rd_addr = addr_q;
  assign bus.pad_zero    = pad_q;
  assign bus.ofm_wr_en   = wr_en_q;
  assign bus.ofm_wr_addr = wr_addr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
endmodule

// File: doc/expand3_layer_ctrl.md
EXPAND3_LAYER_CTRL -- requirements
Module: expand3_layer_ctrl

Interface
REQ-001 Parameters SHALL be: WOUT, default 16, output map side; CHIN, default 64, input channels; KERNEL_DIM, default 3, kernel side; TAPS, default KERNEL_DIM**2*CHIN, MACs per output pixel.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-003 start input 1: one-cycle request to run the layer.
REQ-004 hold input 1: upstream not ready; pauses sequencing.
REQ-005 layer_sample input 1: datapath pulse, one per completed output pixel.
REQ-006 ram_feedback input 1: downstream has consumed the layer output.
REQ-007 ifm_rd_addr output clog2(WOUT**2*CHIN): input feature RAM read address.
REQ-008 ifm_rd_en output 1: read strobe.
REQ-009 pad_zero output 1: current tap is padding; datapath substitutes 0.
REQ-010 layer_en output 1: datapath enable.
REQ-011 ofm_wr_en output 1: output RAM write strobe.
REQ-012 ofm_wr_addr output clog2(WOUT**2): output pixel index.
REQ-013 busy output 1: high from start accept until done.
REQ-014 done output 1: layer complete, held until ram_feedback.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 -> RUN next cycle, all counters cleared; start in any other state SHALL be ignored.
REQ-017 RUN with hold=0: ifm_rd_en=1, layer_en=1, tap counter advances by one per cycle.
REQ-018 RUN with hold=1: ifm_rd_en=0, layer_en=0, all counters frozen.
REQ-019 Tap order SHALL be ky, then kx, then c, with c fastest: tap = (ky*KERNEL_DIM+kx)*CHIN+c.
REQ-020 Input row and column SHALL be iy=oy+ky-1 and ix=ox+kx-1.
REQ-021 If iy or ix is outside 0..WOUT-1: pad_zero=1 and ifm_rd_addr=0; otherwise pad_zero=0 and ifm_rd_addr=(iy*WOUT+ix)*CHIN+c.
REQ-022 Address and pad outputs SHALL be registered: they are valid in the same cycle as their ifm_rd_en.
REQ-023 When tap=TAPS-1, tap SHALL wrap to 0 and the output pixel (ox fastest, then oy) SHALL advance.
REQ-024 layer_en SHALL remain high across a pixel boundary with no gap cycle.
REQ-025 After the last tap of pixel WOUT**2-1 the FSM SHALL go to DRAIN, with ifm_rd_en=0 and layer_en=0.
REQ-026 Each layer_sample SHALL produce ofm_wr_en=1 one cycle later, with ofm_wr_addr equal to the sample count; the count then increments. This applies in RUN and DRAIN.
REQ-027 DRAIN -> DONE on the cycle the WOUT**2-th layer_sample is written.
REQ-028 Extra samples arriving in DONE or IDLE SHALL be ignored, with no write.
REQ-029 DONE: done=1, busy=1. ram_feedback=1 -> IDLE next cycle, done=0, busy=0.
REQ-030 A ram_feedback seen before DONE SHALL be latched and SHALL cause exit on the first DONE cycle.
REQ-031 Counter widths SHALL hold TAPS and WOUT**2 without overflow; all arithmetic is unsigned.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, clear all counters, and drive all outputs to 0; this applies at any point, including mid-RUN.
REQ-033 After rst release the block SHALL wait for a new start.

Verification
REQ-034 Reset, start, hold=0 -> RUN; cycle 1 gives pad_zero=1 (oy=0, ky=0); layer_en stays high continuously for exactly 256*576=147456 cycles, then DRAIN.
REQ-035 Pixel (ox=5, oy=7), tap ky=1, kx=1, c=3 -> ifm_rd_addr=(7*16+5)*64+3=7491, pad_zero=0.
REQ-036 hold=1 for 10 cycles mid-pixel -> no ifm_rd_en, layer_en=0, and the address is identical before and after the hold.
REQ-037 Feed 256 layer_sample pulses -> 256 writes with addresses 0..255, then done=1. A 257th sample produces no write. ram_feedback -> IDLE, done=0.
REQ-038 rst pulse at pixel 100 -> all outputs 0 within the reset cycle; a new start restarts at address/pixel 0.
REQ-039 start pulsed during RUN -> no effect on counters; ram_feedback pulsed during DRAIN -> done lasts exactly one cycle.
